// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared size constants for the synchronous FIFO
//
// Purpose : default data width and depth for fifo/fifo_mem, plus the
//           pointer width derived from the depth.
// Ports   : none (package).
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 32;
   localparam int FIFO_DEPTH      = 8;
   localparam int FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH);

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH storage array for the FIFO
//
// Purpose : plain storage with one synchronous write port and one
//           combinational read port. Contents are deliberately not reset.
//           The parent only ever registers read_data on an accepted read,
//           so stale entries cannot leak out.
// Ports   : clock         - write clock
//           write_enable  - store write_data at write_address this edge
//           write_address - slot to write
//           write_data    - value to store
//           read_address  - slot to look at (the FIFO read pointer)
//           read_data     - combinational contents of read_address
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_address,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_address,
   output logic [DATA_WIDTH-1:0] read_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (write_enable) begin
         mem[write_address] <= write_data;
      end
   end

   assign read_data = mem[read_address];

endmodule : fifo_mem

// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock first-in first-out buffer with registered output
//
// Purpose : DEPTH-entry FIFO. The pointers, the occupancy counter and the
//           flags are kept here, and the storage lives in fifo_mem. Read
//           data is registered, so q shows the popped entry right after
//           the edge that accepts the read.
// Ports   : clock        - single clock, rising edge
//           reset        - asynchronous, active-high reset
//           data         - write data
//           write_enable - write request
//           read_enable  - read request
//           q            - registered read data, held when no read is accepted
//           fifo_full    - occupancy == DEPTH
//           fifo_empty   - occupancy == 0
module fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  write_enable,
   input  logic                  read_enable,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  fifo_full,
   output logic                  fifo_empty
);

   localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);

   logic [ADDR_WIDTH-1:0] write_pointer;
   logic [ADDR_WIDTH-1:0] read_pointer;
   logic [ADDR_WIDTH:0]   count;
   logic [DATA_WIDTH-1:0] mem_read_data;
   logic                  read_accept;
   logic                  write_accept;

   // A read needs something stored. A write may proceed when full only if
   // a read frees the oldest slot at the same edge. Because the read side
   // only looks at the flag, a write into an empty FIFO is never bypassed
   // to q.
   assign read_accept  = read_enable && !fifo_empty;
   assign write_accept = write_enable && (!fifo_full || read_accept);

   assign fifo_full  = (count == FULL_COUNT);
   assign fifo_empty = (count == '0);

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clock         (clock),
      .write_enable  (write_accept),
      .write_address (write_pointer),
      .write_data    (data),
      .read_address  (read_pointer),
      .read_data     (mem_read_data)
   );

   // Pointers are exactly ADDR_WIDTH wide, so a plain increment wraps
   // modulo DEPTH for the power-of-two depths supported.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         write_pointer <= '0;
         read_pointer  <= '0;
      end else begin
         if (write_accept) begin
            write_pointer <= write_pointer + PTR_ONE;
         end
         if (read_accept) begin
            read_pointer <= read_pointer + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else begin
         case ({write_accept, read_accept})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (read_accept) begin
         q <= mem_read_data;
      end
   end

endmodule : fifo

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - scoreboard testbench for fifo
module tb_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] data = '0;
   logic          write_enable = 1'b0;
   logic          read_enable = 1'b0;
   logic [DW-1:0] q;
   logic          fifo_full;
   logic          fifo_empty;

   int            vectors = 0;
   int            miscompares = 0;
   logic [DW-1:0] sb [$];
   logic [DW-1:0] exp_q = '0;

   always #5 clock = ~clock;

   fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(3)) dut (
      .clock        (clock),
      .reset        (reset),
      .data         (data),
      .write_enable (write_enable),
      .read_enable  (read_enable),
      .q            (q),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty)
   );

   function automatic logic exp_full();
      return sb.size() == DEPTH;
   endfunction

   function automatic logic exp_empty();
      return sb.size() == 0;
   endfunction

   // Drive one cycle from a negedge, update the reference queue, and return
   // at the following negedge with outputs settled.
   task automatic step(input logic we, input logic re, input logic [DW-1:0] d);
      logic rd_ok;
      logic wr_ok;
      write_enable = we;
      read_enable  = re;
      data         = d;
      rd_ok = re && (sb.size() != 0);
      wr_ok = we && ((sb.size() < DEPTH) || rd_ok);
      if (rd_ok) exp_q = sb.pop_front();
      if (wr_ok) sb.push_back(d);
      @(posedge clock);
      @(negedge clock);
      write_enable = 1'b0;
      read_enable  = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      step(1'b1, 1'b0, 32'd5);
      step(1'b0, 1'b1, '0);
      vectors++;
      if (q !== 32'd5) begin
         miscompares++;
         $display("FAIL reset_pre_q: got %0h want 5", q);
      end
      #2 reset = 1'b1;
      #1;
      sb.delete();
      exp_q = '0;
      vectors++;
      if (q !== '0) begin
         miscompares++;
         $display("FAIL reset_async_q: got %0h want 0", q);
      end
      vectors++;
      if ({fifo_full, fifo_empty} !== 2'b01) begin
         miscompares++;
         $display("FAIL reset_async_flags: got full=%b empty=%b want 0/1", fifo_full, fifo_empty);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_single();
      step(1'b1, 1'b0, 32'd2);
      vectors++;
      if ({q, fifo_full, fifo_empty} !== {32'd0, 2'b00}) begin
         miscompares++;
         $display("FAIL single_write: got q=%0h full=%b empty=%b want q=0 full=0 empty=0", q, fifo_full, fifo_empty);
      end
      step(1'b0, 1'b1, '0);
      vectors++;
      if ({q, fifo_full, fifo_empty} !== {32'd2, 2'b01} || exp_q !== 32'd2) begin
         miscompares++;
         $display("FAIL single_read: got q=%0h full=%b empty=%b want q=2 full=0 empty=1", q, fifo_full, fifo_empty);
      end
   endtask

   task automatic test_read_empty();
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 32'hdead);
         vectors++;
         if ({q, fifo_full, fifo_empty} !== {32'd2, 2'b01}) begin
            miscompares++;
            $display("FAIL read_empty_%0d: got q=%0h full=%b empty=%b want q=2 full=0 empty=1", i, q, fifo_full, fifo_empty);
         end
      end
      // read and write together while empty: only the write lands
      step(1'b1, 1'b1, 32'd7);
      vectors++;
      if ({q, fifo_full, fifo_empty} !== {32'd2, 2'b00}) begin
         miscompares++;
         $display("FAIL no_bypass: got q=%0h full=%b empty=%b want q=2 full=0 empty=0", q, fifo_full, fifo_empty);
      end
      step(1'b0, 1'b1, '0);
      vectors++;
      if ({q, fifo_empty} !== {32'd7, 1'b1}) begin
         miscompares++;
         $display("FAIL no_bypass_drain: got q=%0h empty=%b want q=7 empty=1", q, fifo_empty);
      end
   endtask

   task automatic test_fill_overflow();
      for (int v = 3; v <= 11; v++) begin
         step(1'b1, 1'b0, DW'(v));
         vectors++;
         if ({q, fifo_full, fifo_empty} !== {32'd7, (v >= 10), 1'b0} || fifo_full !== exp_full()) begin
            miscompares++;
            $display("FAIL fill_%0d: got q=%0h full=%b empty=%b want q=7 full=%b empty=0", v, q, fifo_full, fifo_empty, v >= 10);
         end
      end
      for (int i = 0; i < 9; i++) begin
         step(1'b0, 1'b1, '0);
         vectors++;
         if (q !== exp_q || q !== DW'((i < 8) ? 3 + i : 10) || fifo_empty !== (i >= 7) || fifo_full !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_%0d: got q=%0d full=%b empty=%b want q=%0d full=0 empty=%b", i, q, fifo_full, fifo_empty, (i < 8) ? 3 + i : 10, i >= 7);
         end
      end
   endtask

   task automatic test_simul_full();
      for (int v = 1; v <= 8; v++) step(1'b1, 1'b0, DW'(v));
      vectors++;
      if ({fifo_full, fifo_empty} !== 2'b10) begin
         miscompares++;
         $display("FAIL simul_filled: got full=%b empty=%b want 1/0", fifo_full, fifo_empty);
      end
      step(1'b1, 1'b1, 32'd9);
      vectors++;
      if ({q, fifo_full, fifo_empty} !== {32'd1, 2'b10}) begin
         miscompares++;
         $display("FAIL simul_rw: got q=%0d full=%b empty=%b want q=1 full=1 empty=0", q, fifo_full, fifo_empty);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, '0);
         vectors++;
         if (q !== exp_q || q !== DW'(i + 2) || fifo_empty !== (i == 7)) begin
            miscompares++;
            $display("FAIL simul_drain_%0d: got q=%0d empty=%b want q=%0d empty=%b", i, q, fifo_empty, i + 2, i == 7);
         end
      end
   endtask

   task automatic test_wrap_reset();
      for (int i = 0; i < 20; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), DW'(32'h100 + i));
         vectors++;
         if ({q, fifo_full, fifo_empty} !== {exp_q, exp_full(), exp_empty()}) begin
            miscompares++;
            $display("FAIL wrap_%0d: got q=%0h full=%b empty=%b want q=%0h full=%b empty=%b", i, q, fifo_full, fifo_empty, exp_q, exp_full(), exp_empty());
         end
      end
      while (sb.size() != 0) step(1'b0, 1'b1, '0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(32'h200 + i));
      vectors++;
      if ({fifo_full, fifo_empty} !== 2'b00 || sb.size() != 3) begin
         miscompares++;
         $display("FAIL held3: got full=%b empty=%b want 0/0", fifo_full, fifo_empty);
      end
      #2 reset = 1'b1;
      #1;
      sb.delete();
      exp_q = '0;
      vectors++;
      if ({q, fifo_full, fifo_empty} !== {32'd0, 2'b01}) begin
         miscompares++;
         $display("FAIL midop_reset: got q=%0h full=%b empty=%b want q=0 full=0 empty=1", q, fifo_full, fifo_empty);
      end
      @(negedge clock);
      reset = 1'b0;
      step(1'b0, 1'b1, '0);
      vectors++;
      if ({q, fifo_empty} !== {32'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL post_reset_empty_read: got q=%0h empty=%b want q=0 empty=1", q, fifo_empty);
      end
      step(1'b1, 1'b0, 32'h55);
      step(1'b0, 1'b1, '0);
      vectors++;
      if ({q, fifo_empty} !== {32'h55, 1'b1}) begin
         miscompares++;
         $display("FAIL post_reset_new: got q=%0h empty=%b want q=55 empty=1", q, fifo_empty);
      end
      step(1'b0, 1'b1, '0);
      vectors++;
      if ({q, fifo_empty} !== {32'h55, 1'b1}) begin
         miscompares++;
         $display("FAIL post_reset_stale: got q=%0h empty=%b want q=55 empty=1", q, fifo_empty);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_read_empty();
      test_fill_overflow();
      test_simul_full();
      test_wrap_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_fifo
